// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

   localparam int DMEM_WORD_BYTES = 8;
   localparam int DMEM_ADDR_W     = 64;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} dmem_arb_state_t;

   typedef struct packed {
      logic                   we;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [63:0]            wdata;
   } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if #(
   parameter int ADDR_W = 64
);
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0]        req_we;
   logic [ADDR_W-1:0] req_addr  [2];
   logic [63:0]       req_wdata [2];
   logic [1:0]        resp_valid;
   logic              resp_err;
   logic [63:0]       resp_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_wdata;
   logic              mem_we;
   logic              mem_re;
   logic [63:0]       mem_rdata;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
             mem_addr, mem_wdata, mem_we, mem_re
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
             mem_addr, mem_wdata, mem_we, mem_re
   );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select; on a tie the port not granted last wins.
module rr_arbiter2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       grant_valid_o,
   output logic       winner_o
);
   assign grant_valid_o = |valid_i;
   assign winner_o      = (&valid_i) ? ~last_grant_i : valid_i[1];
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the LSU (port 0) and debug loader (port 1).
// state  | meaning
// IDLE   | arbitrate; handshake latches the request
// ACCESS | drive memory one cycle (skipped on error), capture load data
// RESP   | pulse resp_valid for the owner
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MEM_BYTES = 1024,
   parameter int ADDR_W    = 64
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   dmem_arb_state_t   state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              owner_q, owner_d;
   dmem_req_t         req_q, req_d;
   logic [1:0]        resp_valid_q, resp_valid_d;
   logic              resp_err_q, resp_err_d;
   logic [63:0]       resp_rdata_q, resp_rdata_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [63:0]       mem_wdata_q, mem_wdata_d;
   logic [1:0]        req_ready_c;
   logic              mem_we_c, mem_re_c;
   logic              arb_valid, arb_winner, req_err;

   rr_arbiter2 u_arb (
      .valid_i       (bus.req_valid),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (arb_valid),
      .winner_o      (arb_winner)
   );

   assign req_err = (req_q.addr[2:0] != 3'b000) ||
                    (req_q.addr > DMEM_ADDR_W'(MEM_BYTES - DMEM_WORD_BYTES));

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      req_d        = req_q;
      resp_valid_d = '0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      req_ready_c  = '0;
      mem_we_c     = 1'b0;
      mem_re_c     = 1'b0;
      case (state_q)
         IDLE: begin
            if (arb_valid) begin
               // ready only goes to a valid winner, so arb_valid is the handshake
               req_ready_c[arb_winner] = 1'b1;
               state_d      = ACCESS;
               owner_d      = arb_winner;
               last_grant_d = arb_winner;
               req_d.we     = bus.req_we[arb_winner];
               req_d.addr   = DMEM_ADDR_W'(bus.req_addr[arb_winner]);
               req_d.wdata  = bus.req_wdata[arb_winner];
            end
         end
         ACCESS: begin
            state_d               = RESP;
            resp_valid_d[owner_q] = 1'b1;
            resp_err_d            = req_err;
            if (!req_err) begin
               mem_addr_d  = req_q.addr[ADDR_W-1:0];
               mem_wdata_d = req_q.wdata;
               mem_we_c    = req_q.we;
               mem_re_c    = ~req_q.we;
               if (!req_q.we) resp_rdata_d = bus.mem_rdata;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         req_q        <= '0;
         resp_valid_q <= '0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         req_q        <= req_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign bus.req_ready  = req_ready_c;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.mem_addr   = mem_addr_d;
   assign bus.mem_wdata  = mem_wdata_d;
   assign bus.mem_we     = mem_we_c;
   assign bus.mem_re     = mem_re_c;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: memory model plus a response scoreboard fed at each handshake.
module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(64)) bif ();

   dmem_arbiter #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   logic [63:0] mem     [128];
   logic [63:0] ref_mem [128];

   assign bif.mem_rdata = mem[bif.mem_addr[9:3]];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 128; i++) mem[i] <= 64'd0;
         mem[0] <= 64'd5;
      end else if (bif.mem_we) begin
         mem[bif.mem_addr[9:3]] <= bif.mem_wdata;
      end
   end

   typedef struct {
      int          port;
      logic        err;
      logic [63:0] rdata;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          grants[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          last_hs = -100;
   int          resp_count = 0;
   logic [63:0] last_rdata = '0;
   logic        last_err = 1'b0;
   logic        mem_act_seen = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: push expected response at each handshake, pop on resp_valid.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
         last_hs = -100;
         for (int i = 0; i < 128; i++) ref_mem[i] = 64'd0;
         ref_mem[0] = 64'd5;
      end else begin
         if (bif.mem_we || bif.mem_re) mem_act_seen = 1'b1;
         checks++;
         if (bif.req_ready == 2'b11) begin
            failures++;
            $display("FAIL ready_both cyc=%0d req_ready=%b required not 11", cyc, bif.req_ready);
         end
         checks++;
         if (bif.req_ready != 2'b00 && cyc < last_hs + 3) begin
            failures++;
            $display("FAIL ready_not_idle cyc=%0d req_ready=%b required 00 (last handshake %0d)",
                     cyc, bif.req_ready, last_hs);
         end
         if (bif.resp_valid != 2'b00) begin
            resp_count++;
            last_rdata = bif.resp_rdata;
            last_err   = bif.resp_err;
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL unexpected_resp cyc=%0d resp_valid=%b required 00", cyc, bif.resp_valid);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (bif.resp_valid !== (2'b01 << e.port) || bif.resp_err !== e.err ||
                   bif.resp_rdata !== e.rdata || cyc != e.due) begin
                  failures++;
                  $display("FAIL resp cyc=%0d valid=%b err=%b rdata=%h required cyc=%0d valid=%b err=%b rdata=%h",
                           cyc, bif.resp_valid, bif.resp_err, bif.resp_rdata,
                           e.due, 2'b01 << e.port, e.err, e.rdata);
               end
            end
         end else begin
            checks++;
            if (bif.resp_err !== 1'b0 || bif.resp_rdata !== 64'd0) begin
               failures++;
               $display("FAIL resp_idle_zero cyc=%0d err=%b rdata=%h required 0", cyc, bif.resp_err, bif.resp_rdata);
            end
         end
         if (sb.size() > 0 && cyc > sb[0].due) begin
            failures++;
            checks++;
            $display("FAIL resp_missing cyc=%0d required resp at cyc=%0d", cyc, sb[0].due);
            void'(sb.pop_front());
         end
         for (int p = 0; p < 2; p++) begin
            if (bif.req_valid[p] && bif.req_ready[p]) begin
               exp_t        e;
               logic [63:0] a;
               a       = bif.req_addr[p];
               e.port  = p;
               e.err   = (a[2:0] != 3'b000) || (a > 64'd1016);
               e.rdata = 64'd0;
               e.due   = cyc + 2;
               if (!e.err) begin
                  if (bif.req_we[p]) ref_mem[a[9:3]] = bif.req_wdata[p];
                  else               e.rdata = ref_mem[a[9:3]];
               end
               sb.push_back(e);
               last_hs = cyc;
            end
         end
      end
   end

   task automatic apply_reset();
      bif.req_valid = 2'b00;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_reqs(input int max_cyc);
      int         n;
      logic [1:0] hs;
      n = 0;
      while (bif.req_valid != 2'b00 && n < max_cyc) begin
         @(negedge clk);
         hs = bif.req_valid & bif.req_ready;
         for (int p = 0; p < 2; p++) if (hs[p]) grants.push_back(p);
         @(posedge clk);
         #1 bif.req_valid = bif.req_valid & ~hs;
         n++;
      end
      checks++;
      if (bif.req_valid != 2'b00) begin
         failures++;
         $display("FAIL handshake_timeout pending=%b required 00", bif.req_valid);
         bif.req_valid = 2'b00;
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || bif.resp_valid != 2'b00) && n < 10) begin
         @(negedge clk);
         #1 n++;
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout outstanding=%0d required 0", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int p, input logic we, input logic [63:0] addr, input logic [63:0] wd);
      bif.req_we[p]    = we;
      bif.req_addr[p]  = addr;
      bif.req_wdata[p] = wd;
      bif.req_valid[p] = 1'b1;
      run_reqs(20);
      drain();
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      checks++;
      if ({bif.req_ready, bif.resp_valid, bif.resp_err, bif.mem_we, bif.mem_re} !== 7'd0) begin
         failures++;
         $display("FAIL reset_ctrl ready=%b resp_valid=%b err=%b we=%b re=%b required 0",
                  bif.req_ready, bif.resp_valid, bif.resp_err, bif.mem_we, bif.mem_re);
      end
      checks++;
      if (bif.resp_rdata !== 64'd0 || bif.mem_addr !== 64'd0 || bif.mem_wdata !== 64'd0) begin
         failures++;
         $display("FAIL reset_data rdata=%h addr=%h wdata=%h required 0",
                  bif.resp_rdata, bif.mem_addr, bif.mem_wdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_store_load();
      int c0;
      c0 = resp_count;
      issue(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D);
      issue(0, 1'b0, 64'h10, 64'd0);
      checks++;
      if (last_rdata !== 64'hDEADBEEF_CAFEF00D || last_err !== 1'b0) begin
         failures++;
         $display("FAIL store_load rdata=%h err=%b required DEADBEEFCAFEF00D err=0", last_rdata, last_err);
      end
      checks++;
      if (resp_count != c0 + 2) begin
         failures++;
         $display("FAIL store_load_count got %0d responses required 2", resp_count - c0);
      end
   endtask

   task automatic test_tie();
      apply_reset();
      grants.delete();
      for (int p = 0; p < 2; p++) begin
         bif.req_we[p] = 1'b0; bif.req_addr[p] = 64'h0; bif.req_wdata[p] = 64'd0;
      end
      bif.req_valid = 2'b11;
      run_reqs(20);
      drain();
      checks++;
      if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
         failures++;
         $display("FAIL tie_order got %p required '{0, 1}", grants);
      end
      checks++;
      if (last_rdata !== 64'd5) begin
         failures++;
         $display("FAIL tie_data rdata=%h required 5", last_rdata);
      end
   endtask

   task automatic test_errors();
      mem_act_seen = 1'b0;
      issue(0, 1'b0, 64'h0C, 64'd0);
      checks++;
      if (last_err !== 1'b1 || last_rdata !== 64'd0) begin
         failures++;
         $display("FAIL err_misaligned err=%b rdata=%h required err=1 rdata=0", last_err, last_rdata);
      end
      issue(1, 1'b0, 64'h3FC, 64'd0);
      checks++;
      if (last_err !== 1'b1 || last_rdata !== 64'd0) begin
         failures++;
         $display("FAIL err_range err=%b rdata=%h required err=1 rdata=0", last_err, last_rdata);
      end
      checks++;
      if (mem_act_seen !== 1'b0) begin
         failures++;
         $display("FAIL err_mem_access mem_act=%b required 0", mem_act_seen);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] hs;
      grants.delete();
      bif.req_we    = 2'b00;
      bif.req_addr[0] = 64'h10; bif.req_addr[1] = 64'h18;
      bif.req_valid = 2'b11;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         hs = bif.req_valid & bif.req_ready;
         for (int p = 0; p < 2; p++) if (hs[p]) grants.push_back(p);
      end
      @(posedge clk);
      #1 bif.req_valid = 2'b00;
      drain();
      checks++;
      if (grants.size() != 4 || grants[0] != 0 || grants[1] != 1 || grants[2] != 0 || grants[3] != 1) begin
         failures++;
         $display("FAIL alternate got %p required '{0, 1, 0, 1}", grants);
      end
   endtask

   task automatic test_reset_abort();
      int c0;
      bif.req_we[1] = 1'b1; bif.req_addr[1] = 64'h20; bif.req_wdata[1] = 64'hAAAA5555_1234ABCD;
      bif.req_valid[1] = 1'b1;
      @(negedge clk);
      checks++;
      if (bif.req_ready !== 2'b10) begin
         failures++;
         $display("FAIL abort_grant ready=%b required 10", bif.req_ready);
      end
      @(posedge clk);
      #1 bif.req_valid = 2'b00;
      reset = 1'b1;
      c0 = resp_count;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if ({bif.req_ready, bif.resp_valid, bif.resp_err, bif.mem_we, bif.mem_re} !== 7'd0 ||
          bif.resp_rdata !== 64'd0 || bif.mem_addr !== 64'd0 || bif.mem_wdata !== 64'd0) begin
         failures++;
         $display("FAIL abort_outputs ready=%b valid=%b err=%b we=%b re=%b addr=%h wdata=%h required 0",
                  bif.req_ready, bif.resp_valid, bif.resp_err, bif.mem_we, bif.mem_re,
                  bif.mem_addr, bif.mem_wdata);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (resp_count != c0) begin
         failures++;
         $display("FAIL abort_no_resp got %0d responses required 0", resp_count - c0);
      end
      @(posedge clk);
      #1 bif.req_we[0] = 1'b0; bif.req_addr[0] = 64'h20; bif.req_valid[0] = 1'b1;
      @(negedge clk);
      checks++;
      if (bif.req_ready !== 2'b01) begin
         failures++;
         $display("FAIL abort_idle ready=%b required 01", bif.req_ready);
      end
      @(posedge clk);
      #1 bif.req_valid = 2'b00;
      drain();
      checks++;
      if (last_rdata !== 64'd0 || last_err !== 1'b0) begin
         failures++;
         $display("FAIL abort_mem rdata=%h err=%b required 0", last_rdata, last_err);
      end
   endtask

   task automatic test_last_addr();
      issue(0, 1'b1, 64'h3F8, 64'h01234567_89ABCDEF);
      issue(1, 1'b0, 64'h3F8, 64'd0);
      checks++;
      if (last_rdata !== 64'h01234567_89ABCDEF || last_err !== 1'b0) begin
         failures++;
         $display("FAIL last_addr rdata=%h err=%b required 0123456789ABCDEF err=0", last_rdata, last_err);
      end
   endtask

   initial begin
      bif.req_valid = 2'b00;
      bif.req_we    = 2'b00;
      for (int p = 0; p < 2; p++) begin
         bif.req_addr[p]  = 64'd0;
         bif.req_wdata[p] = 64'd0;
      end
      test_reset();
      test_store_load();
      test_tie();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      test_last_addr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
